// File: rtl/i2s_beamform_top_if.sv
// Bundle of the I2S line and the sample/beamformer result signals.
// The master modport is the receiver side, the slave modport is whatever consumes it.
interface i2s_beamform_top_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  i_sd2;
    logic                  o_sck;
    logic                  o_ws2;
    logic [DATA_WIDTH-1:0] o_left_data2;
    logic [DATA_WIDTH-1:0] o_right_data2;
    logic                  o_left_vld2;
    logic                  o_right_vld2;
    logic [DATA_WIDTH-1:0] horizontal_out;
    logic [7:0]            led_pattern;
    logic                  beam_forming_valid;

    modport master (
        input  i_sd2,
        output o_sck, o_ws2, o_left_data2, o_right_data2, o_left_vld2, o_right_vld2,
        output horizontal_out, led_pattern, beam_forming_valid
    );

    modport slave (
        output i_sd2,
        input  o_sck, o_ws2, o_left_data2, o_right_data2, o_left_vld2, o_right_vld2,
        input  horizontal_out, led_pattern, beam_forming_valid
    );
endinterface

// File: rtl/i2s_beamform_top.sv
// I2S master receiver with an 8-direction delay-and-sum beamformer.
// Left is delayed 4 frames; right history taps 0..7 give the candidate alignments.
module i2s_beamform_top #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned BLOCK_LEN  = 64,
    parameter int unsigned ACC_W      = 32
) (
    input logic                i_sys_clk,
    input logic                rst,
    i2s_beamform_top_if.master bus
);
    localparam int unsigned NumDir = 8;
    localparam int unsigned LDelay = 4;
    localparam int unsigned SumW   = DATA_WIDTH + 1;
    localparam int unsigned DivW   = $clog2(CLK_DIV + 1);
    localparam int unsigned FrmW   = $clog2(BLOCK_LEN + 1);

    typedef enum logic [0:0] {StIdle, StSearch} state_e;

    logic [DivW-1:0]       div_q, div_d;
    logic                  sck_q, sck_d, ws_q, ws_d;
    logic [4:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, left_q, left_d, right_q, right_d, hz_q, hz_d;
    logic                  started_q, started_d, lvld_q, lvld_d, rvld_q, rvld_d, bfv_q, bfv_d;
    logic [DATA_WIDTH-1:0] r_hist_q [NumDir];
    logic [DATA_WIDTH-1:0] r_hist_d [NumDir];
    logic [DATA_WIDTH-1:0] l_hist_q [LDelay];
    logic [DATA_WIDTH-1:0] l_hist_d [LDelay];
    logic [ACC_W-1:0]      acc_q [NumDir];
    logic [ACC_W-1:0]      acc_d [NumDir];
    logic [FrmW-1:0]       frm_q, frm_d;
    logic [2:0]            sel_q, sel_d, idx_q, idx_d, best_idx_q, best_idx_d;
    logic [7:0]            led_q, led_d;
    logic [ACC_W-1:0]      best_val_q, best_val_d;
    state_e                state_q, state_d;

    logic [DATA_WIDTH-1:0] word, l_old;
    logic [DATA_WIDTH-1:0] r_new [NumDir];
    logic [SumW-1:0]       sum_s [NumDir];
    logic [SumW-1:0]       mag [NumDir];
    logic [ACC_W-1:0]      acc_sat [NumDir];
    logic [ACC_W:0]        acc_ext;
    logic                  tick, rise, fall, frame_step, take;
    logic [2:0]            cur_idx;
    logic [ACC_W-1:0]      cur_val;

    // Per-direction sums and saturated accumulator updates for the incoming frame.
    always_comb begin
        word     = {shift_q[DATA_WIDTH-2:0], bus.i_sd2};
        l_old    = l_hist_q[LDelay-1];
        r_new[0] = word;
        for (int k = 1; k < NumDir; k++) r_new[k] = r_hist_q[k-1];
        acc_ext = '0;
        for (int k = 0; k < NumDir; k++) begin
            sum_s[k]   = {l_old[DATA_WIDTH-1], l_old} + {r_new[k][DATA_WIDTH-1], r_new[k]};
            mag[k]     = sum_s[k][SumW-1] ? (~sum_s[k] + SumW'(1)) : sum_s[k];
            acc_ext    = {1'b0, acc_q[k]} + {{(ACC_W + 1 - SumW){1'b0}}, mag[k]};
            acc_sat[k] = acc_ext[ACC_W] ? '1 : acc_ext[ACC_W-1:0];
        end
    end

    // Next state: clock generation, capture, frame step and argmax search.
    always_comb begin
        div_d      = div_q;
        sck_d      = sck_q;
        bit_d      = bit_q;
        ws_d       = ws_q;
        shift_d    = shift_q;
        started_d  = started_q;
        left_d     = left_q;
        right_d    = right_q;
        lvld_d     = 1'b0;
        rvld_d     = 1'b0;
        bfv_d      = 1'b0;
        hz_d       = hz_q;
        r_hist_d   = r_hist_q;
        l_hist_d   = l_hist_q;
        acc_d      = acc_q;
        frm_d      = frm_q;
        sel_d      = sel_q;
        led_d      = led_q;
        state_d    = state_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        frame_step = 1'b0;
        take       = 1'b0;
        cur_idx    = best_idx_q;
        cur_val    = best_val_q;

        tick = (div_q == DivW'(CLK_DIV - 1));
        rise = tick && !sck_q;
        fall = tick && sck_q;
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick) sck_d = ~sck_q;
        if (fall) begin
            bit_d = bit_q + 5'd1;
            ws_d  = bit_d[4];
        end

        if (rise) begin
            shift_d = word;
            // The LSB lands one bit after the word-select edge that ends the word.
            if (bit_q == 5'd16) begin
                left_d    = word;
                lvld_d    = 1'b1;
                started_d = 1'b1;
            end else if (bit_q == 5'd0 && started_q) begin
                right_d    = word;
                rvld_d     = 1'b1;
                frame_step = 1'b1;
            end
        end

        if (frame_step) begin
            for (int k = 0; k < NumDir; k++) begin
                r_hist_d[k] = r_new[k];
                acc_d[k]    = acc_sat[k];
            end
            l_hist_d[0] = left_q;
            for (int j = 1; j < LDelay; j++) l_hist_d[j] = l_hist_q[j-1];
            hz_d = sum_s[sel_q][SumW-1:1];
            if (frm_q == FrmW'(BLOCK_LEN - 1)) begin
                frm_d      = '0;
                state_d    = StSearch;
                idx_d      = '0;
                best_idx_d = '0;
                best_val_d = '0;
            end else begin
                frm_d = frm_q + FrmW'(1);
            end
        end

        case (state_q)
            StSearch: begin
                // Strict compare keeps the lowest index on ties.
                take       = (idx_q == 3'd0) || (acc_q[idx_q] > best_val_q);
                cur_idx    = take ? idx_q : best_idx_q;
                cur_val    = take ? acc_q[idx_q] : best_val_q;
                best_idx_d = cur_idx;
                best_val_d = cur_val;
                if (idx_q == 3'(NumDir - 1)) begin
                    led_d          = '0;
                    led_d[cur_idx] = 1'b1;
                    sel_d          = cur_idx;
                    bfv_d          = 1'b1;
                    for (int k = 0; k < NumDir; k++) acc_d[k] = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge i_sys_clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            sck_q      <= 1'b0;
            bit_q      <= '0;
            ws_q       <= 1'b0;
            shift_q    <= '0;
            started_q  <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            lvld_q     <= 1'b0;
            rvld_q     <= 1'b0;
            bfv_q      <= 1'b0;
            hz_q       <= '0;
            for (int k = 0; k < NumDir; k++) begin
                r_hist_q[k] <= '0;
                acc_q[k]    <= '0;
            end
            for (int j = 0; j < LDelay; j++) l_hist_q[j] <= '0;
            frm_q      <= '0;
            sel_q      <= '0;
            led_q      <= '0;
            state_q    <= StIdle;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            div_q      <= div_d;
            sck_q      <= sck_d;
            bit_q      <= bit_d;
            ws_q       <= ws_d;
            shift_q    <= shift_d;
            started_q  <= started_d;
            left_q     <= left_d;
            right_q    <= right_d;
            lvld_q     <= lvld_d;
            rvld_q     <= rvld_d;
            bfv_q      <= bfv_d;
            hz_q       <= hz_d;
            r_hist_q   <= r_hist_d;
            l_hist_q   <= l_hist_d;
            acc_q      <= acc_d;
            frm_q      <= frm_d;
            sel_q      <= sel_d;
            led_q      <= led_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

    assign bus.o_sck              = sck_q;
    assign bus.o_ws2              = ws_q;
    assign bus.o_left_data2       = left_q;
    assign bus.o_right_data2      = right_q;
    assign bus.o_left_vld2        = lvld_q;
    assign bus.o_right_vld2       = rvld_q;
    assign bus.horizontal_out     = hz_q;
    assign bus.led_pattern        = led_q;
    assign bus.beam_forming_valid = bfv_q;
endmodule

// File: tb/tb_i2s_beamform_top.sv
// Bench for i2s_beamform_top: frame-indexed sample streams, closed-form timing model
// and an array-based beamformer reference checked every system clock.
module tb_i2s_beamform_top;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_beamform_top_if #(.DATA_WIDTH(DW)) bus ();

    i2s_beamform_top #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (4),
        .BLOCK_LEN (64),
        .ACC_W     (32)
    ) dut (
        .i_sys_clk(clk),
        .rst      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int phase = 0;

    logic [15:0] lq [0:299];
    logic [15:0] rq [0:299];
    logic [15:0] seq [16] = '{16'd1200, 16'd3400, -16'sd2100, 16'd2800, -16'sd1500, -16'sd3900,
                              -16'sd1100, 16'd2600, 16'd1800, -16'sd3300, 16'd1400, 16'd3700,
                              16'd2200, -16'sd2900, -16'sd1600, -16'sd3100};

    longint      acc_m [8];
    int          sel_m, blk_frames, deadline, bf_count;
    logic [7:0]  led_cur, led_next;
    logic [15:0] hz_m, left_m, right_m;
    bit          pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) acc_m[k] = 0;
        sel_m = 0; blk_frames = 0; deadline = 0; bf_count = 0;
        led_cur = 8'h00; led_next = 8'h00; hz_m = '0; left_m = '0; right_m = '0;
        pending = 1'b0;
    endtask

    // Bit on the data line during bit-slot c of I2S frame g (one-bit delayed, MSB first).
    function automatic logic sd_bit(input int tt);
        int c = (tt / 8) % 32;
        int g = tt / 256;
        logic [15:0] w;
        if (c >= 1 && c <= 16) begin
            w = lq[g];
            return w[16 - c];
        end else if (c >= 17) begin
            w = rq[g];
            return w[32 - c];
        end else if (g >= 1) begin
            w = rq[g - 1];
            return w[0];
        end
        return 1'b0;
    endfunction

    // Reference beamformer for frame n: left 4 frames old, right k frames old, zero before reset.
    task automatic frame_step(input int n);
        int s [8];
        int ld, rk, best;
        longint mag;
        ld = (n >= 4) ? int'($signed(lq[n - 4])) : 0;
        for (int k = 0; k < 8; k++) begin
            rk = (n >= k) ? int'($signed(rq[n - k])) : 0;
            s[k] = ld + rk;
            mag = (s[k] < 0) ? -s[k] : s[k];
            acc_m[k] = acc_m[k] + mag;
            if (acc_m[k] > 64'sd4294967295) acc_m[k] = 64'sd4294967295;
        end
        hz_m = 16'(s[sel_m] >>> 1);
        blk_frames++;
        if (blk_frames == 64) begin
            best = 0;
            for (int k = 1; k < 8; k++) if (acc_m[k] > acc_m[best]) best = k;
            led_next = 8'(1 << best);
            sel_m = best;
            for (int k = 0; k < 8; k++) acc_m[k] = 0;
            blk_frames = 0;
            pending = 1'b1;
            deadline = t + 16;
        end
    endtask

    // Model update, output comparison and serial data drive, once per system clock.
    always @(negedge clk) begin
        int n;
        if (rst) begin
            model_reset();
            t = 0;
            check("rst_ctl", 64'({bus.o_sck, bus.o_ws2, bus.o_left_vld2, bus.o_right_vld2,
                                  bus.beam_forming_valid}), 64'd0);
            check("rst_left", 64'(bus.o_left_data2), 64'd0);
            check("rst_right", 64'(bus.o_right_data2), 64'd0);
            check("rst_hz", 64'(bus.horizontal_out), 64'd0);
            check("rst_led", 64'(bus.led_pattern), 64'd0);
            bus.i_sd2 = 1'b0;
        end else begin
            t = t + 1;
            check("sck", 64'(bus.o_sck), 64'((t / 4) % 2));
            check("ws", 64'(bus.o_ws2), 64'(((t / 8) % 32) >= 16));

            if (t % 256 == 132) begin
                n = t / 256;
                left_m = lq[n];
                if (phase == 1 && n < 4) check("left_8001", 64'(bus.o_left_data2), 64'h8001);
                if (phase == 1 && n == 4) check("left_fff6", 64'(bus.o_left_data2), 64'hFFF6);
            end
            check("left_vld", 64'(bus.o_left_vld2), 64'(t % 256 == 132));

            if (t >= 260 && t % 256 == 4) begin
                n = t / 256 - 1;
                right_m = rq[n];
                frame_step(n);
                if (phase == 1 && n < 4) check("right_3333", 64'(bus.o_right_data2), 64'h3333);
                if (phase == 0 && n >= 128)
                    check("hz_aligned", 64'(bus.horizontal_out), 64'(lq[n - 4]));
            end
            check("right_vld", 64'(bus.o_right_vld2), 64'(t >= 260 && t % 256 == 4));

            check("left_data", 64'(bus.o_left_data2), 64'(left_m));
            check("right_data", 64'(bus.o_right_data2), 64'(right_m));
            check("horizontal", 64'(bus.horizontal_out), 64'(hz_m));

            if (bus.beam_forming_valid) begin
                check("bfv_expected", 64'(pending), 64'd1);
                if (pending) begin
                    check("led_decision", 64'(bus.led_pattern), 64'(led_next));
                    if (phase == 0 && bf_count == 0)
                        check("led_block1", 64'(bus.led_pattern), 64'h10);
                    if (phase == 0 && bf_count == 1)
                        check("led_block2", 64'(bus.led_pattern), 64'h04);
                    led_cur = led_next;
                    pending = 1'b0;
                    bf_count++;
                end
            end else if (pending && t > deadline) begin
                check("bfv_timeout", 64'(bus.beam_forming_valid), 64'd1);
                pending = 1'b0;
            end
            if (!pending) check("led", 64'(bus.led_pattern), 64'(led_cur));

            bus.i_sd2 = sd_bit(t);
        end
    end

    initial begin
        // Phase 0: identical periodic channels, then right = left delayed 2 frames.
        for (int n = 0; n < 300; n++) begin
            lq[n] = (n < 64) ? seq[n % 16] : 16'($urandom);
            rq[n] = (n < 64) ? lq[n] : lq[n - 2];
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        repeat (138 * 256 + 60) @(negedge clk);
        #2;
        check("blocks_phase0", 64'(bf_count), 64'd2);
        // Mid-word reset during the left word.
        rst = 1'b1;
        phase = 1;
        for (int n = 0; n < 300; n++) begin
            lq[n] = (n < 4) ? 16'h8001 : (n == 4) ? 16'hFFF6 : 16'($urandom);
            rq[n] = (n < 4) ? 16'h3333 : 16'($urandom);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (66 * 256 + 20) @(negedge clk);
        #2;
        check("blocks_phase1", 64'(bf_count), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
